down_timer: RTL
===============

Name: down_timer

Overview:
- Loadable down-counting timer. It is the count-down counterpart of the team's loadable up-counter.
- Counts a preloaded value down to zero on qualified clock enables and flags terminal count.
- Supports one-shot and periodic (auto-reload) modes, with start/stop/resume control.
- Sits beside the up-counter in the timing/sequencing datapath: timeouts, tick generation, delay loops.

Parameters:
- WIDTH, 5, bit width of the count and reload value.

Ports:
- clk  input  1  clock, all state updates on its rising edge.
- rst  input  1  reset; synchronous, active-high.
- load  input  1  capture cnt_in into the reload register and the count; return to IDLE.
- enab  input  1  count qualifier; decrement happens only in RUN with enab=1.
- start  input  1  begin counting from IDLE/DONE, or resume from HOLD.
- stop  input  1  pause counting (RUN -> HOLD).
- periodic  input  1  1 = auto-reload at terminal count; 0 = one-shot.
- cnt_in  input  WIDTH  load value.
- cnt_out  output  WIDTH  current count (registered).
- tc  output  1  one-cycle registered pulse at terminal count.
- busy  output  1  high while in RUN.
- done  output  1  high while in DONE.

Behaviour:
- Reset values: state=IDLE, cnt_out=0, reload register=0, tc=0. Therefore busy=0 and done=0.
- States and outputs:
  - IDLE: armed, not counting.
  - RUN: counting.
  - HOLD: paused, count frozen.
  - DONE: one-shot expired.
  - busy = (state==RUN); done = (state==DONE). Both are decoded from registered state, so there is no combinational path from inputs.
- Per-cycle priority: rst > load > stop > start > count.
- load:
  - reload <= cnt_in; cnt_out <= cnt_in; state <= IDLE; tc <= 0.
  - Legal in any state, including mid-RUN; it aborts the run.
- stop:
  - In RUN, state <= HOLD; cnt_out holds; no decrement that cycle.
  - In any other state, no effect.
- start:
  - From IDLE, HOLD or DONE with cnt_out!=0: state <= RUN. The first decrement can occur the following cycle.
  - From IDLE/HOLD/DONE with cnt_out==0: state <= DONE, tc pulses next cycle (immediate expiry).
  - In RUN: ignored.
- Count (RUN, enab=1, no higher-priority event):
  - If cnt_out > 1: cnt_out <= cnt_out-1.
  - If cnt_out == 1: terminal count, tc <= 1 for exactly one cycle.
    - periodic=1 and reload!=0: cnt_out <= reload; stay in RUN. Period = reload enabled cycles.
    - periodic=0 or reload==0: cnt_out <= 0; state <= DONE.
- RUN with enab=0: hold the value, no tc.
- tc defaults to 0 every cycle unless set by a terminal-count or immediate-expiry event.
- Arithmetic:
  - Unsigned, WIDTH bits. Decrement never wraps below 0, because the count==1 case is handled explicitly.
  - Max load 2^WIDTH-1 is legal (31 cycles for WIDTH=5).
- periodic is sampled at the terminal-count cycle only; changing it mid-run takes effect at the next expiry.
- rst mid-operation: all registers return to reset values on the next edge; the reload register is cleared.
- Next-state and next-count logic is a single combinational function of (state, inputs, cnt_out, reload), registered in one clocked process.

Decomposition:
- Shared package timer_pkg:
  - state encoding constants IDLE=2'd0, RUN=2'd1, HOLD=2'd2, DONE=2'd3;
  - default WIDTH.
- No sub-module: the next-state/next-count function stays inside down_timer.
- Optional reuse: the existing up-counter for an external tick prescaler feeding enab (not part of this block).

Test Plan:
- Reset then idle: rst=1 for 2 cycles -> cnt_out=0, tc=0, busy=0, done=0; start with count 0 -> done=1 and tc pulse next cycle.
- One-shot: load cnt_in=5, periodic=0, start, enab=1 continuously -> cnt_out 5,4,3,2,1,0. tc=1 exactly on the cycle cnt_out becomes 0. done=1 afterwards, busy=0, cnt_out stays 0.
- Periodic: load 3, periodic=1, start, enab=1 for 12 cycles -> cnt_out 3,2,1,3,2,1,... with tc every 3rd enabled cycle; busy stays 1.
- Enable gating/pause: load 4, start, enab toggling 1,0,1,0 -> decrement only on enab=1 cycles. stop at cnt_out=2 -> HOLD, value frozen at 2 despite enab=1. start -> resume to 1, then 0 with tc.
- Simultaneous events: in RUN at cnt_out=1 with load=1, cnt_in=7, stop=1, enab=1 -> cnt_out=7, state IDLE, tc=0. Next, start+stop together in RUN -> HOLD.
- Boundaries: load 31 (WIDTH=5), periodic=1, run 62 enabled cycles -> exactly 2 tc pulses, no wrap past 0. Periodic with load 0 and start -> immediate DONE, single tc. rst asserted mid-RUN -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - shared state encoding and defaults for the timer family
package timer_pkg;

    localparam int DEFAULT_WIDTH = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2,
        DONE = 2'd3
    } timer_state_t;

endpackage

// File: rtl/down_timer.sv
// rtl/down_timer.sv - loadable down-counting timer with one-shot/periodic modes
module down_timer
    import timer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             enab,
    input  logic             start,
    input  logic             stop,
    input  logic             periodic,
    input  logic [WIDTH-1:0] cnt_in,
    output logic [WIDTH-1:0] cnt_out,
    output logic             tc,
    output logic             busy,
    output logic             done
);

    localparam logic [WIDTH-1:0] ZERO = '0;
    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    timer_state_t     state, state_nxt;
    logic [WIDTH-1:0] reload, reload_nxt;
    logic [WIDTH-1:0] cnt_nxt;
    logic             tc_nxt;

    always_comb begin
        state_nxt  = state;
        reload_nxt = reload;
        cnt_nxt    = cnt_out;
        tc_nxt     = 1'b0;
        if (load) begin
            reload_nxt = cnt_in;
            cnt_nxt    = cnt_in;
            state_nxt  = IDLE;
        end else if (stop && state == RUN) begin
            state_nxt = HOLD;
        end else if (start && state != RUN) begin
            // A zero count expires immediately rather than entering RUN
            if (cnt_out != ZERO) begin
                state_nxt = RUN;
            end else begin
                state_nxt = DONE;
                tc_nxt    = 1'b1;
            end
        end else if (state == RUN && enab) begin
            if (cnt_out > ONE) begin
                cnt_nxt = cnt_out - ONE;
            end else if (cnt_out == ONE) begin
                tc_nxt = 1'b1;
                if (periodic && reload != ZERO) begin
                    cnt_nxt = reload;
                end else begin
                    cnt_nxt   = ZERO;
                    state_nxt = DONE;
                end
            end else begin
                state_nxt = DONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            reload  <= ZERO;
            cnt_out <= ZERO;
            tc      <= 1'b0;
        end else begin
            state   <= state_nxt;
            reload  <= reload_nxt;
            cnt_out <= cnt_nxt;
            tc      <= tc_nxt;
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule
